id_stage: RTL
=============

Name: id_stage

Overview:
Instruction-decode stage directly downstream of the fetch stage. It consumes the registered fetch outputs (PC, instruction), reads the 32x32 integer register file, extracts the RV32I immediate, and presents everything to execute through an ID/EX pipeline register with stall and flush control. It also owns the register-file write port driven from writeback.

Parameters:
XLEN, 32, datapath and register width
NOP_INST, 32'h00000013, bubble instruction (addi x0,x0,0) inserted on flush/reset

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  asynchronous, active-high reset
stall_i  input  1  hold the ID/EX register
flush_i  input  1  replace the next ID/EX contents with a bubble
if_pc_i  input  32  PC from fetch pipeline register
if_inst_i  input  32  instruction from fetch pipeline register
wb_en_i  input  1  register-file write enable
wb_rd_i  input  5  write destination
wb_data_i  input  32  write data
id_pc_o  output  32  registered PC
id_inst_o  output  32  registered instruction
rs1_data_o  output  32  registered rs1 operand
rs2_data_o  output  32  registered rs2 operand
imm_o  output  32  registered sign-extended immediate
rs1_addr_o  output  5  registered inst[19:15]
rs2_addr_o  output  5  registered inst[24:20]
rd_addr_o  output  5  registered inst[11:7]
valid_o  output  1  ID/EX holds a real instruction
illegal_o  output  1  registered: opcode not in RV32I base set

Behaviour:
- Reset (async, rst_i=1): all 31 writable registers cleared to 0; id_inst_o=NOP_INST; valid_o=0; illegal_o=0; all other outputs 0. Outputs take reset values immediately, independent of clk_i.
- Register file: x0 reads 0 always; writes with wb_rd_i=0 ignored. Write occurs on rising edge when wb_en_i=1.
- Write-first bypass: if wb_en_i=1, wb_rd_i!=0 and wb_rd_i equals rs1 (or rs2) of if_inst_i in the same cycle, the captured operand is wb_data_i, not the stale array value.
- Immediate decode on if_inst_i[6:0]: I-type (0000011, 0010011, 1100111, 1110011): sext(inst[31:20]); S (0100011): sext({inst[31:25],inst[11:7]}); B (1100011): sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}); U (0110111, 0010111): {inst[31:12],12'b0}; J (1101111): sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}); R (0110011) and others: 0.
- illegal: opcode not in the list above, or inst[1:0]!=2'b11. Captured with the instruction; no trap generated here.
- ID/EX update priority per rising edge: flush_i > stall_i > normal.
  - flush_i=1: id_inst_o=NOP_INST, valid_o=0, illegal_o=0, rd/rs addresses 0, data/imm 0, id_pc_o=0. Applies even if stall_i=1.
  - stall_i=1, flush_i=0: all ID/EX outputs hold. Register-file writes still occur.
  - else: capture decoded fields of if_pc_i/if_inst_i; valid_o=1.
- Latency: one cycle from if_inst_i/if_pc_i to ID/EX outputs. A write at edge N is visible to a read sampled at edge N via bypass, and from the array thereafter.
- A stalled instruction holds operands captured at entry; no re-read during stall (hazard unit owns forwarding into a held slot).
- Reset deasserted mid-operation: first edge after release captures the current if_* inputs normally.

Test Plan:
- Reset: assert rst_i between edges -> outputs clear immediately, id_inst_o=0x00000013, valid_o=0; read of x5 after release returns 0.
- Write/read: wb_en_i=1, rd=5, data=0xDEADBEEF at edge N; at edge N+1 if_inst_i=0x00028093 (addi x1,x5,0) -> rs1_data_o=0xDEADBEEF, imm_o=0, rd_addr_o=1.
- Bypass + x0: same-cycle write x7=0x12345678 with if_inst_i=0x007302B3 (add x5,x6,x7) -> rs2_data_o=0x12345678; write x0=0xFFFFFFFF then read x0 -> 0.
- Immediates: 0xFFF00093 -> imm_o=0xFFFFFFFF; 0xFE000EE3 (beq, offset -4) -> 0xFFFFFFFC; 0x123450B7 (lui) -> 0x12345000; 0x0080006F (jal +8) -> 0x00000008.
- Stall/flush: stall_i=1 for 3 cycles with changing if_inst_i -> outputs unchanged; stall_i=1 and flush_i=1 together -> bubble, valid_o=0.
- Illegal: if_inst_i=0x0000007F -> illegal_o=1, valid_o=1; if_inst_i=0x00000000 -> illegal_o=1.

Source files
------------

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: register file with write-first bypass,
// immediate/legality decode and the ID/EX pipeline register with flush/stall.
module id_stage #(
    parameter int unsigned XLEN     = 32,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] if_pc_i,
    input  logic [31:0]     if_inst_i,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] id_pc_o,
    output logic [31:0]     id_inst_o,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] imm_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic            valid_o,
    output logic            illegal_o
);

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic            valid;
        logic            illegal;
    } idex_t;

    localparam idex_t IDEX_BUBBLE = '{
        pc:       '0,
        inst:     NOP_INST,
        rs1_data: '0,
        rs2_data: '0,
        imm:      '0,
        rs1_addr: '0,
        rs2_addr: '0,
        rd_addr:  '0,
        valid:    1'b0,
        illegal:  1'b0
    };

    logic [XLEN-1:0] regs_q [32];
    logic [XLEN-1:0] regs_d [32];
    idex_t           idex_q;
    idex_t           idex_d;

    logic [6:0]      opcode;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;
    logic            legal;
    imm_fmt_e        imm_fmt;
    logic            wb_hit;

    assign opcode   = if_inst_i[6:0];
    assign rs1_addr = if_inst_i[19:15];
    assign rs2_addr = if_inst_i[24:20];
    assign rd_addr  = if_inst_i[11:7];
    assign wb_hit   = wb_en_i && (wb_rd_i != 5'd0);

    // Register file: x0 is never written, so its entry stays at reset zero.
    always_comb begin
        for (int unsigned i = 0; i < 32; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wb_hit) begin
            regs_d[wb_rd_i] = wb_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Write-first read: a same-cycle writeback to the source wins over the array.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1_addr != 5'd0) begin
            rs1_val = (wb_hit && wb_rd_i == rs1_addr) ? wb_data_i : regs_q[rs1_addr];
        end
        if (rs2_addr != 5'd0) begin
            rs2_val = (wb_hit && wb_rd_i == rs2_addr) ? wb_data_i : regs_q[rs2_addr];
        end
    end

    always_comb begin
        imm_fmt = IMM_NONE;
        legal   = 1'b1;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: imm_fmt = IMM_I;
            7'b0100011:                                     imm_fmt = IMM_S;
            7'b1100011:                                     imm_fmt = IMM_B;
            7'b0110111, 7'b0010111:                         imm_fmt = IMM_U;
            7'b1101111:                                     imm_fmt = IMM_J;
            7'b0110011:                                     imm_fmt = IMM_NONE;
            default:                                        legal   = 1'b0;
        endcase
        if (if_inst_i[1:0] != 2'b11) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        imm_val = '0;
        case (imm_fmt)
            IMM_I: imm_val = {{(XLEN-12){if_inst_i[31]}}, if_inst_i[31:20]};
            IMM_S: imm_val = {{(XLEN-12){if_inst_i[31]}}, if_inst_i[31:25], if_inst_i[11:7]};
            IMM_B: imm_val = {{(XLEN-13){if_inst_i[31]}}, if_inst_i[31], if_inst_i[7],
                              if_inst_i[30:25], if_inst_i[11:8], 1'b0};
            IMM_U: imm_val = {{(XLEN-32){if_inst_i[31]}}, if_inst_i[31:12], 12'b0};
            IMM_J: imm_val = {{(XLEN-21){if_inst_i[31]}}, if_inst_i[31], if_inst_i[19:12],
                              if_inst_i[20], if_inst_i[30:21], 1'b0};
            default: imm_val = '0;
        endcase
    end

    // Flush beats stall; a stalled slot keeps the operands it captured on entry.
    always_comb begin
        idex_d = idex_q;
        if (flush_i) begin
            idex_d = IDEX_BUBBLE;
        end else if (!stall_i) begin
            idex_d.pc       = if_pc_i;
            idex_d.inst     = if_inst_i;
            idex_d.rs1_data = rs1_val;
            idex_d.rs2_data = rs2_val;
            idex_d.imm      = imm_val;
            idex_d.rs1_addr = rs1_addr;
            idex_d.rs2_addr = rs2_addr;
            idex_d.rd_addr  = rd_addr;
            idex_d.valid    = 1'b1;
            idex_d.illegal  = !legal;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idex_q <= IDEX_BUBBLE;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_pc_o    = idex_q.pc;
    assign id_inst_o  = idex_q.inst;
    assign rs1_data_o = idex_q.rs1_data;
    assign rs2_data_o = idex_q.rs2_data;
    assign imm_o      = idex_q.imm;
    assign rs1_addr_o = idex_q.rs1_addr;
    assign rs2_addr_o = idex_q.rs2_addr;
    assign rd_addr_o  = idex_q.rd_addr;
    assign valid_o    = idex_q.valid;
    assign illegal_o  = idex_q.illegal;

endmodule
